// File: rtl/controle_contador_cascata_if.sv
// Command/status bundle between the user-side sequencer logic and the cascaded counter controller.
// The master drives command strobes and targets; the slave reports counts and FSM status.
interface controle_contador_cascata_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] target_lo;
    logic [3:0] target_hi;
    logic [3:0] cnt_lo;
    logic [3:0] cnt_hi;
    logic       carry;
    logic [1:0] state;
    logic       done;
    logic       busy;

    modport master (
        output start, stop, clear, target_lo, target_hi,
        input  cnt_lo, cnt_hi, carry, state, done, busy
    );

    modport slave (
        input  start, stop, clear, target_lo, target_hi,
        output cnt_lo, cnt_hi, carry, state, done, busy
    );
endinterface

// File: rtl/controle_contador_cascata.sv
// Start/pause/resume/clear sequencer for a prescaled mod-LO_MOD / mod-HI_MOD counter pair
// that stops on a latched terminal value (0/0 means free-running).
module controle_contador_cascata #(
    parameter int DIV    = 4,
    parameter int LO_MOD = 12,
    parameter int HI_MOD = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    controle_contador_cascata_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [3:0]     LO_LAST    = 4'(LO_MOD - 1);
    localparam logic [3:0]     HI_LAST    = 4'(HI_MOD - 1);

    logic [1:0]    state_reg,  state_next;
    logic [3:0]    cnt_lo_reg, cnt_lo_next;
    logic [3:0]    cnt_hi_reg, cnt_hi_next;
    logic [PW-1:0] presc_reg,  presc_next;
    logic [3:0]    tgt_lo_reg, tgt_lo_next;
    logic [3:0]    tgt_hi_reg, tgt_hi_next;
    logic          done_reg,   done_next;

    logic          tick;
    logic          carry_w;
    logic [3:0]    lo_adv;
    logic [3:0]    hi_adv;
    logic [3:0]    hi_after;
    logic          terminal;
    logic [3:0]    tgt_lo_clamped;
    logic [3:0]    tgt_hi_clamped;

    // A tick is only taken when the cycle really advances: a stop or clear that
    // cycle freezes/zeroes the count, so carry must not claim an advance either.
    assign tick     = (state_reg == S_RUN) && !bus.clear && !bus.stop
                      && (presc_reg == PRESC_LAST);
    assign carry_w  = tick && (cnt_lo_reg == LO_LAST);
    assign lo_adv   = (cnt_lo_reg == LO_LAST) ? 4'd0 : cnt_lo_reg + 4'd1;
    assign hi_adv   = (cnt_hi_reg == HI_LAST) ? 4'd0 : cnt_hi_reg + 4'd1;
    assign hi_after = carry_w ? hi_adv : cnt_hi_reg;
    assign terminal = tick && ({tgt_hi_reg, tgt_lo_reg} != 8'd0)
                      && (lo_adv == tgt_lo_reg) && (hi_after == tgt_hi_reg);

    assign tgt_lo_clamped = (32'(bus.target_lo) >= LO_MOD) ? LO_LAST : bus.target_lo;
    assign tgt_hi_clamped = (32'(bus.target_hi) >= HI_MOD) ? HI_LAST : bus.target_hi;

    always_comb begin
        state_next  = state_reg;
        cnt_lo_next = cnt_lo_reg;
        cnt_hi_next = cnt_hi_reg;
        presc_next  = presc_reg;
        tgt_lo_next = tgt_lo_reg;
        tgt_hi_next = tgt_hi_reg;
        done_next   = 1'b0;

        if (bus.clear) begin
            state_next  = S_IDLE;
            cnt_lo_next = 4'd0;
            cnt_hi_next = 4'd0;
            presc_next  = '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    // stop has no meaning here, so start launches regardless of it
                    if (bus.start) begin
                        state_next  = S_RUN;
                        cnt_lo_next = 4'd0;
                        cnt_hi_next = 4'd0;
                        presc_next  = '0;
                        tgt_lo_next = tgt_lo_clamped;
                        tgt_hi_next = tgt_hi_clamped;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state_next = S_PAUSE;
                    end else begin
                        presc_next = tick ? '0 : PW'(presc_reg + 1'b1);
                        if (tick) begin
                            cnt_lo_next = lo_adv;
                            cnt_hi_next = hi_after;
                        end
                        if (terminal) begin
                            state_next = S_DONE;
                            done_next  = 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.stop) begin
                        state_next  = S_IDLE;
                        cnt_lo_next = 4'd0;
                        cnt_hi_next = 4'd0;
                        presc_next  = '0;
                    end else if (bus.start) begin
                        state_next = S_RUN;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_lo_reg <= 4'd0;
            cnt_hi_reg <= 4'd0;
            presc_reg  <= '0;
            tgt_lo_reg <= 4'd0;
            tgt_hi_reg <= 4'd0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_lo_reg <= cnt_lo_next;
            cnt_hi_reg <= cnt_hi_next;
            presc_reg  <= presc_next;
            tgt_lo_reg <= tgt_lo_next;
            tgt_hi_reg <= tgt_hi_next;
            done_reg   <= done_next;
        end
    end

    assign bus.cnt_lo = cnt_lo_reg;
    assign bus.cnt_hi = cnt_hi_reg;
    assign bus.carry  = carry_w;
    assign bus.state  = state_reg;
    assign bus.done   = done_reg;
    assign bus.busy   = (state_reg == S_RUN) || (state_reg == S_PAUSE);

endmodule

// File: tb/tb_controle_contador_cascata.sv
// Directed bench for the cascaded counter controller (DIV=4, mod-12 / mod-10).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_controle_contador_cascata;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    controle_contador_cascata_if bus ();

    controle_contador_cascata #(.DIV(4), .LO_MOD(12), .HI_MOD(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [3:0] lo, input logic [3:0] hi);
        bus.target_lo = lo;
        bus.target_hi = hi;
        bus.start     = 1'b1;
        step(1);
        bus.start     = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < limit) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({bus.state, bus.cnt_hi, bus.cnt_lo, bus.done, bus.busy} !== 12'd0) begin
            $display("FAIL reset_state: got st=%b hi=%0d lo=%0d done=%b busy=%b, want all 0",
                     bus.state, bus.cnt_hi, bus.cnt_lo, bus.done, bus.busy);
            n_bad++;
        end
        step(1);
        rst = 1'b0;
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        n_cmp++;
        if (bus.state !== 2'b00) begin
            $display("FAIL idle_stop: got state=%b, want 00", bus.state);
            n_bad++;
        end
        $display("test_reset: state=%b cnt=%0d/%0d", bus.state, bus.cnt_hi, bus.cnt_lo);
    endtask

    task automatic test_free_run();
        int carries;
        carries = 0;
        do_start(4'd0, 4'd0);
        for (int i = 0; i < 48; i++) begin
            n_cmp++;
            if (bus.cnt_lo !== 4'((i / 4) % 12)) begin
                $display("FAIL free_lo[%0d]: got %0d, want %0d", i, bus.cnt_lo, (i / 4) % 12);
                n_bad++;
            end
            if (bus.carry === 1'b1) carries++;
            step(1);
        end
        n_cmp++;
        if (carries != 1) begin
            $display("FAIL free_carry_count: got %0d, want 1", carries);
            n_bad++;
        end
        n_cmp++;
        if (bus.cnt_lo !== 4'd0 || bus.cnt_hi !== 4'd1) begin
            $display("FAIL free_48: got %0d/%0d, want 1/0", bus.cnt_hi, bus.cnt_lo);
            n_bad++;
        end
        step(432);
        n_cmp++;
        if (bus.cnt_lo !== 4'd0 || bus.cnt_hi !== 4'd0 || bus.state !== 2'b01) begin
            $display("FAIL free_480: got %0d/%0d st=%b, want 0/0 st=01",
                     bus.cnt_hi, bus.cnt_lo, bus.state);
            n_bad++;
        end
        do_clear();
        n_cmp++;
        if (bus.state !== 2'b00 || bus.cnt_lo !== 4'd0) begin
            $display("FAIL free_clear: got st=%b lo=%0d, want 00/0", bus.state, bus.cnt_lo);
            n_bad++;
        end
        $display("test_free_run: carries=%0d final=%0d/%0d", carries, bus.cnt_hi, bus.cnt_lo);
    endtask

    task automatic test_target();
        int cycles;
        do_start(4'd3, 4'd1);
        wait_done(200, cycles);
        n_cmp++;
        if (cycles != 60) begin
            $display("FAIL target_latency: got %0d cycles, want 60", cycles);
            n_bad++;
        end
        n_cmp++;
        if (bus.cnt_hi !== 4'd1 || bus.cnt_lo !== 4'd3 || bus.state !== 2'b11
            || bus.busy !== 1'b0 || bus.carry !== 1'b0) begin
            $display("FAIL target_final: got %0d/%0d st=%b busy=%b carry=%b, want 1/3 st=11 busy=0 carry=0",
                     bus.cnt_hi, bus.cnt_lo, bus.state, bus.busy, bus.carry);
            n_bad++;
        end
        step(1);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.cnt_lo !== 4'd3 || bus.state !== 2'b11) begin
            $display("FAIL target_pulse: got done=%b lo=%0d st=%b, want 0/3/11",
                     bus.done, bus.cnt_lo, bus.state);
            n_bad++;
        end
        $display("test_target: done after %0d cycles at %0d/%0d", cycles, bus.cnt_hi, bus.cnt_lo);
    endtask

    task automatic test_pause();
        int cycles;
        do_start(4'd3, 4'd1);
        step(22);
        n_cmp++;
        if (bus.cnt_lo !== 4'd5) begin
            $display("FAIL pause_pre: got lo=%0d, want 5", bus.cnt_lo);
            n_bad++;
        end
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        step(8);
        n_cmp++;
        if (bus.state !== 2'b10 || bus.cnt_lo !== 4'd5 || bus.busy !== 1'b1) begin
            $display("FAIL pause_frozen: got st=%b lo=%0d busy=%b, want 10/5/1",
                     bus.state, bus.cnt_lo, bus.busy);
            n_bad++;
        end
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        wait_done(200, cycles);
        n_cmp++;
        if (cycles + 32 != 70) begin
            $display("FAIL pause_latency: got %0d cycles, want 70", cycles + 32);
            n_bad++;
        end
        n_cmp++;
        if (bus.cnt_hi !== 4'd1 || bus.cnt_lo !== 4'd3) begin
            $display("FAIL pause_final: got %0d/%0d, want 1/3", bus.cnt_hi, bus.cnt_lo);
            n_bad++;
        end
        $display("test_pause: done after %0d cycles", cycles + 32);
    endtask

    task automatic test_priority();
        do_start(4'd0, 4'd0);
        step(5);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        step(1);
        bus.clear = 1'b0;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.state !== 2'b00 || bus.cnt_lo !== 4'd0) begin
            $display("FAIL prio_clear_start: got st=%b lo=%0d, want 00/0", bus.state, bus.cnt_lo);
            n_bad++;
        end
        do_start(4'd0, 4'd0);
        step(9);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        n_cmp++;
        if (bus.state !== 2'b10 || bus.cnt_lo !== 4'd2) begin
            $display("FAIL prio_start_stop: got st=%b lo=%0d, want 10/2", bus.state, bus.cnt_lo);
            n_bad++;
        end
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        n_cmp++;
        if (bus.state !== 2'b00 || bus.cnt_lo !== 4'd0 || bus.busy !== 1'b0) begin
            $display("FAIL prio_abort: got st=%b lo=%0d busy=%b, want 00/0/0",
                     bus.state, bus.cnt_lo, bus.busy);
            n_bad++;
        end
        $display("test_priority: state=%b", bus.state);
    endtask

    task automatic test_async_reset();
        do_start(4'd0, 4'd0);
        step(30);
        n_cmp++;
        if (bus.cnt_lo !== 4'd7) begin
            $display("FAIL arst_pre: got lo=%0d, want 7", bus.cnt_lo);
            n_bad++;
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.state !== 2'b00 || bus.cnt_lo !== 4'd0 || bus.cnt_hi !== 4'd0 || bus.done !== 1'b0) begin
            $display("FAIL arst_immediate: got st=%b %0d/%0d done=%b, want 00 0/0 0",
                     bus.state, bus.cnt_hi, bus.cnt_lo, bus.done);
            n_bad++;
        end
        @(negedge clk);
        rst = 1'b0;
        do_start(4'd0, 4'd0);
        step(4);
        n_cmp++;
        if (bus.state !== 2'b01 || bus.cnt_lo !== 4'd1 || bus.cnt_hi !== 4'd0) begin
            $display("FAIL arst_fresh: got st=%b %0d/%0d, want 01 0/1",
                     bus.state, bus.cnt_hi, bus.cnt_lo);
            n_bad++;
        end
        do_clear();
        $display("test_async_reset: restarted cleanly");
    endtask

    task automatic test_clamp();
        int cycles;
        do_start(4'd13, 4'd12);
        wait_done(600, cycles);
        n_cmp++;
        if (cycles != 476) begin
            $display("FAIL clamp_latency: got %0d cycles, want 476", cycles);
            n_bad++;
        end
        n_cmp++;
        if (bus.cnt_hi !== 4'd9 || bus.cnt_lo !== 4'd11 || bus.state !== 2'b11) begin
            $display("FAIL clamp_final: got %0d/%0d st=%b, want 9/11 st=11",
                     bus.cnt_hi, bus.cnt_lo, bus.state);
            n_bad++;
        end
        $display("test_clamp: done after %0d cycles at %0d/%0d", cycles, bus.cnt_hi, bus.cnt_lo);
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.clear     = 1'b0;
        bus.target_lo = 4'd0;
        bus.target_hi = 4'd0;
        test_reset();
        test_free_run();
        test_target();
        test_pause();
        test_priority();
        test_async_reset();
        test_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
